// File: rtl/lfsr_dr_pkg.sv
// Shared types and the golden XNOR-LFSR step for the dual-rail LFSR receiver.
package lfsr_dr_pkg;
  localparam int LFSR_W = 3;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 3'b000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_HI = 3'd1,
    HOLD   = 3'd2,
    REQ_LO = 3'd3,
    ERROR  = 3'd4
  } state_e;

  // 111 is the lock state of the XNOR form and maps onto itself.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[1], v[0], ~(v[2] ^ v[1])};
  endfunction
endpackage

// File: rtl/dr_sync.sv
// N-bit multi-flop synchronizer with async reset, one shift chain per bit.
module dr_sync #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [STAGES-1:0][N-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/lfsr_dr_receiver.sv
// Clocked 4-phase dual-rail initiator for the async LFSR generator: captures
// each codeword, hands it downstream and checks it against the golden LFSR.
module lfsr_dr_receiver
  import lfsr_dr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             req,
  input  logic             ack,
  input  logic             a0,
  input  logic             a1,
  input  logic             b0,
  input  logic             b1,
  input  logic             c0,
  input  logic             c1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_data,
  output logic             out_mismatch,
  output logic             err_rail,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [CNT_W-1:0] word_count
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  logic [6:0] s;
  logic s_ack, sa0, sa1, sb0, sb1, sc0, sc1;
  logic legal, any11, any00, complete, nul;
  logic [LFSR_W-1:0] value, expected;
  logic [TW-1:0] tcnt;
  state_e state;

  dr_sync #(.N(7), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ack, a0, a1, b0, b1, c0, c1}),
    .q   (s)
  );

  assign {s_ack, sa0, sa1, sb0, sb1, sc0, sc1} = s;

  assign legal    = (sa0 ^ sa1) & (sb0 ^ sb1) & (sc0 ^ sc1);
  assign any11    = (sa0 & sa1) | (sb0 & sb1) | (sc0 & sc1);
  assign any00    = ~(sa0 | sa1) | ~(sb0 | sb1) | ~(sc0 | sc1);
  assign complete = s_ack & legal;
  assign nul      = ~s_ack & ~(|s[5:0]);
  assign value    = {sa1, sb1, sc1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_mismatch <= 1'b0;
      err_rail     <= 1'b0;
      err_timeout  <= 1'b0;
      word_count   <= '0;
      expected     <= LFSR_SEED;
      tcnt         <= '0;
    end else begin
      // Clearing first lets an error raised this same cycle still stick.
      if (err_clr) begin
        err_rail    <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (en) begin
            state <= REQ_HI;
            req   <= 1'b1;
            tcnt  <= '0;
          end
        end
        REQ_HI: begin
          if (any11 || (s_ack && any00)) begin
            state    <= ERROR;
            err_rail <= 1'b1;
            req      <= 1'b0;
          end else if (complete) begin
            state        <= HOLD;
            out_data     <= value;
            out_mismatch <= (value != expected);
            out_valid    <= 1'b1;
          end else if (tcnt == TMAX) begin
            state       <= ERROR;
            err_timeout <= 1'b1;
            req         <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          // req stays high so the generator holds its codeword under backpressure.
          if (out_ready) begin
            state      <= REQ_LO;
            out_valid  <= 1'b0;
            expected   <= lfsr_next(out_data);
            word_count <= word_count + CNT_W'(1);
            req        <= 1'b0;
            tcnt       <= '0;
          end
        end
        REQ_LO: begin
          if (any11) begin
            state    <= ERROR;
            err_rail <= 1'b1;
          end else if (nul) begin
            if (en) begin
              state <= REQ_HI;
              req   <= 1'b1;
              tcnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (tcnt == TMAX) begin
            state       <= ERROR;
            err_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ERROR: begin
          req       <= 1'b0;
          out_valid <= 1'b0;
          if (err_clr && nul) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/lfsr_dr_receiver.md
Name: lfsr_dr_receiver

Overview:
Clocked initiator/consumer for the 4-phase dual-rail req/ack channel driven by the asynchronous 3-bit LFSR generator. It raises req, synchronizes the returning ack and dual-rail pairs (a0/a1, b0/b1, c0/c1), and captures the 3-bit codeword on completion. It returns the channel to null, presents the word on a valid/ready port and checks it against a golden XNOR-LFSR model. It sits at the sync boundary between the async LFSR block and clocked logic.

Parameters:
SYNC_STAGES, 2, flop stages on every async input (ack, six rails); minimum 2
TIMEOUT_CYC, 1024, cycles allowed in any wait state before timeout error
CNT_W, 16, width of captured-word counter

Ports:
clk  input  1  sole clock
rst  input  1  asynchronous, active-high reset
en  input  1  enable issuing new transactions
req  output  1  4-phase request to generator, registered
ack  input  1  async acknowledge from generator
a0, a1, b0, b1, c0, c1  input  1 each  async dual-rail data; value bit v[2]=a, v[1]=b, v[0]=c
out_valid  output  1  captured word available
out_ready  input  1  downstream accepts word
out_data  output  3  captured value {a,b,c}
out_mismatch  output  1  captured word differed from expected; qualified by out_valid
err_rail  output  1  sticky: illegal rail code seen
err_timeout  output  1  sticky: wait-state timeout
err_clr  input  1  clears sticky errors, exits ERROR
word_count  output  CNT_W  words accepted downstream; wraps modulo 2^CNT_W

Behaviour:
- Reset (async): req=0, out_valid=0, out_data=0, out_mismatch=0, err_rail=0, err_timeout=0, word_count=0, expected=3'b000, state=IDLE, synchronizers cleared.
- All FSM decisions use synchronized inputs only; input-to-decision latency is SYNC_STAGES cycles.
- Pair legal when exactly one rail is 1. Codeword complete: ack=1 and all pairs legal. Null: ack=0 and all six rails 0.
- IDLE: req=0. en=1 -> REQ_HI (req=1 the following cycle).
- REQ_HI: req=1. Complete -> HOLD, load out_data, out_mismatch=(value!=expected), out_valid=1. Any pair 11 -> ERROR with err_rail=1. ack=1 while any pair is 00 -> ERROR with err_rail=1.
- HOLD: req stays 1 for backpressure; out_valid=1 until out_ready=1. On the accept cycle: out_valid=0; expected <= next(captured); word_count++; -> REQ_LO with req=0.
- REQ_LO: null -> IDLE, or directly REQ_HI if en=1 (req rises the cycle after null). A pair 11 -> ERROR with err_rail=1.
- next(v) = {v[1], v[0], ~(v[2]^v[1])}. From 000 the sequence is 000,001,011,110,101,010,100,000 (period 7). 111 maps to 111 (lock state); it is accepted and flagged normally.
- Mismatch resynchronizes: the expected value follows the captured word, not the old expected.
- Timeout counter clears on entry to REQ_HI/REQ_LO. Reaching TIMEOUT_CYC in either state -> ERROR with err_timeout=1. HOLD never times out.
- ERROR: req=0, out_valid=0. err_clr=1 clears both sticky flags. The FSM exits to IDLE only when err_clr=1 and null is seen; otherwise it stays in ERROR.
- en deasserted mid-transaction: the current 4-phase cycle completes, then the FSM parks in IDLE.
- err_clr outside ERROR clears the flags only.
- Simultaneous out_ready and err_clr in HOLD: the accept proceeds normally.

Decomposition:
- Package lfsr_dr_pkg: state enum (IDLE, REQ_HI, HOLD, REQ_LO, ERROR), LFSR_W=3, LFSR_SEED=3'b000, function lfsr_next.
- Sub-module dr_sync: parameterized N-bit, SYNC_STAGES-deep synchronizer with async reset, instantiated once for the 7 async inputs.

Test Plan:
- Generator model resets to 000, en=1, out_ready=1 -> out_data sequence 000,001,011,110,101,010,100,000; out_mismatch=0 throughout; word_count=8; req toggles once per word.
- out_ready held 0 for 20 cycles after first capture -> req stays 1, out_valid=1, out_data stable; after release, req falls one cycle later and word_count=1.
- Model drives a0=a1=1 during data phase -> err_rail=1, req=0, out_valid=0. err_clr with rails null -> IDLE, err_rail=0.
- Model never asserts ack, TIMEOUT_CYC=16 -> err_timeout=1 after 16 cycles in REQ_HI; no out_valid.
- Model emits 000 then 111 -> second word out_mismatch=1, expected becomes 111. Next 111 -> mismatch=0.
- rst asserted in HOLD -> req and out_valid drop immediately (async); word_count=0, expected=000. After release, the first capture of 000 shows no mismatch.
